// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//
// Run/pause/clear sequencer for a 4-digit BCD stopwatch counter. It conditions three raw
// active-low keys (start/stop, lap, clear) with a 2-flop synchronizer and a saturating
// debouncer. It divides the clock into count ticks and runs a four-state FSM. The FSM drives
// the counter's enable and clear strobes and a display-hold flag.
//
// Parameters
//   TICK_DIV    clock cycles per count tick (>= 2)
//   DEB_CYCLES  consecutive synchronized-low cycles needed to accept a press (>= 1)
//
// Ports
//   Clock        in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   StartStop_n  in   raw start/stop key, active-low, asynchronous
//   Lap_n        in   raw lap key, active-low, asynchronous
//   Clear_n      in   raw clear key, active-low, asynchronous
//   AtMax        in   counter currently holds 9999
//   CntEn        out  one-cycle count-enable strobe (registered)
//   CntClr       out  one-cycle synchronous clear strobe (registered)
//   Hold         out  freeze the display latch; the counter keeps running
//   State        out  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE (registered)

module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       StartStop_n,
  input  logic       Lap_n,
  input  logic       Clear_n,
  input  logic       AtMax,
  output logic       CntEn,
  output logic       CntClr,
  output logic       Hold,
  output logic [1:0] State
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES);

  localparam int unsigned KeyStart = 0;
  localparam int unsigned KeyLap   = 1;
  localparam int unsigned KeyClr   = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic [2:0] key_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] press;

  assign key_raw = {Clear_n, Lap_n, StartStop_n};

  // Synchronizers reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_key
    logic [DebW-1:0] cnt_q;
    logic [DebW-1:0] cnt_d;
    logic            press_q;

    // Count synchronized-low cycles, saturate at DebMax, and drop to zero on any high cycle.
    always_comb begin
      if (sync2_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == DebMax) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + DebW'(1);
      end
    end

    // The pulse rises together with the counter's first arrival at DebMax. Saturation
    // suppresses any repeat while the key stays held.
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        press_q <= (cnt_d == DebMax) && (cnt_q != DebMax);
      end
    end

    assign press[i] = press_q;
  end

  logic start_p;
  logic lap_p;
  logic clr_p;

  assign start_p = press[KeyStart];
  assign lap_p   = press[KeyLap];
  assign clr_p   = press[KeyClr];

  // ---------------------------------------------------------------------------
  // Prescaler and run-control FSM
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [PreW-1:0] pre_q;
  logic            hold_q;
  logic            cnt_en_q;
  logic            cnt_clr_q;
  logic            tick;

  assign tick = (state_q == StRun) && (pre_q == PreMax);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      hold_q    <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;

      // Prescaler advances only in RUN; it simply holds in PAUSE so a resume finishes the
      // interrupted tick period.
      if (state_q == StRun) begin
        pre_q <= tick ? '0 : pre_q + PreW'(1);
      end

      if (lap_p && (state_q == StRun || state_q == StPause)) begin
        hold_q <= ~hold_q;
      end

      case (state_q)
        StIdle: begin
          if (start_p) begin
            state_q   <= StRun;
            pre_q     <= '0;
            cnt_clr_q <= clr_p;
          end else if (clr_p) begin
            cnt_clr_q <= 1'b1;
          end
        end

        StRun: begin
          // A stop press still honours a coincident tick, but never enters DONE.
          if (start_p) begin
            state_q  <= StPause;
            cnt_en_q <= tick && !AtMax;
          end else if (tick) begin
            if (AtMax) begin
              state_q <= StDone;
            end else begin
              cnt_en_q <= 1'b1;
            end
          end
        end

        StPause: begin
          if (clr_p) begin
            state_q   <= StIdle;
            cnt_clr_q <= 1'b1;
            hold_q    <= 1'b0;
          end else if (start_p) begin
            state_q <= StRun;
          end
        end

        StDone: begin
          if (clr_p) begin
            state_q   <= StIdle;
            cnt_clr_q <= 1'b1;
            hold_q    <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CntEn  = cnt_en_q;
  assign CntClr = cnt_clr_q;
  assign Hold   = hold_q;
  assign State  = state_q;

endmodule
